// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Multi-read-port register file with a per-register pending-write
//            scoreboard for RAW hazard detection. Optional same-cycle
//            writeback forwarding is enabled by defining REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_RD*AW-1:0]   REG_R_Addr,
  output logic [NUM_RD*XLEN-1:0] REG_R_Data,
  output logic [NUM_RD-1:0]      REG_R_Busy,
  output logic                   Hazard,
  input  logic [NUM_RD-1:0]      REG_R_Used,
  input  logic                   Issue_En,
  input  logic [AW-1:0]          Issue_Addr,
  output logic                   Issue_Ready,
  input  logic                   REG_W_En,
  input  logic [AW-1:0]          REG_W_Addr,
  input  logic [XLEN-1:0]        REG_W_Data,
  output logic                   Sb_Err
);

  localparam logic [PEND_W-1:0] c_CNT_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] c_CNT_ONE = PEND_W'(1);

  logic [XLEN-1:0]   r_regs [NUM_REGS];
  logic [PEND_W-1:0] r_cnt  [NUM_REGS];
  logic              r_sb_err;

  logic w_wr;
  logic w_issue_ready;
  logic w_issue_acc;
  logic w_wb_dec;
  logic w_underflow;

  // x0 is never written and its counter never moves, so it reads 0 and is never busy
  assign w_wr          = REG_W_En && (REG_W_Addr != '0);
  assign w_issue_ready = (r_cnt[Issue_Addr] != c_CNT_MAX) ||
                         (REG_W_En && (REG_W_Addr == Issue_Addr));
  assign w_issue_acc   = Issue_En && w_issue_ready && (Issue_Addr != '0);
  assign w_wb_dec      = w_wr && (r_cnt[REG_W_Addr] != '0);
  assign w_underflow   = w_wr && (r_cnt[REG_W_Addr] == '0);

  assign Issue_Ready = w_issue_ready;
  assign Sb_Err      = r_sb_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[REG_W_Addr] <= REG_W_Data;
    end
  end

  // Issue and retire to the same register in one cycle cancel out
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_issue_acc && (Issue_Addr == AW'(i)) &&
            !(w_wb_dec && (REG_W_Addr == AW'(i)))) begin
          r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
        end else if (w_wb_dec && (REG_W_Addr == AW'(i)) &&
                     !(w_issue_acc && (Issue_Addr == AW'(i)))) begin
          r_cnt[i] <= r_cnt[i] - c_CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sb_err <= 1'b0;
    end else if (w_underflow) begin
      r_sb_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = REG_R_Addr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = w_wr && (REG_W_Addr == w_addr);
    assign REG_R_Data[g*XLEN +: XLEN] = w_fwd ? REG_W_Data : r_regs[w_addr];
    // The concurrent writeback retires one of the pending writes
    assign REG_R_Busy[g] = w_fwd ? (r_cnt[w_addr] > c_CNT_ONE)
                                 : (r_cnt[w_addr] != '0);
`else
    assign REG_R_Data[g*XLEN +: XLEN] = r_regs[w_addr];
    assign REG_R_Busy[g] = (r_cnt[w_addr] != '0);
`endif
  end

  assign Hazard = |(REG_R_Busy & REG_R_Used);

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed vectors for regfile_scoreboard (NUM_RD=3); expectations
//            are queued by the driver and compared by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK;
  logic        RST_N;
  logic [14:0] REG_R_Addr;
  logic [95:0] REG_R_Data;
  logic [2:0]  REG_R_Busy;
  logic        Hazard;
  logic [2:0]  REG_R_Used;
  logic        Issue_En;
  logic [4:0]  Issue_Addr;
  logic        Issue_Ready;
  logic        REG_W_En;
  logic [4:0]  REG_W_Addr;
  logic [31:0] REG_W_Data;
  logic        Sb_Err;

  typedef struct {
    int          id;
    logic [31:0] d0, d1, d2;
    logic [2:0]  busy;
    logic        haz, rdy, err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_RD(3), .PEND_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REG_R_Addr(REG_R_Addr), .REG_R_Data(REG_R_Data), .REG_R_Busy(REG_R_Busy),
    .Hazard(Hazard), .REG_R_Used(REG_R_Used),
    .Issue_En(Issue_En), .Issue_Addr(Issue_Addr), .Issue_Ready(Issue_Ready),
    .REG_W_En(REG_W_En), .REG_W_Addr(REG_W_Addr), .REG_W_Data(REG_W_Data),
    .Sb_Err(Sb_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (REG_R_Data[31:0] !== e.d0 || REG_R_Data[63:32] !== e.d1 ||
          REG_R_Data[95:64] !== e.d2 || REG_R_Busy !== e.busy ||
          Hazard !== e.haz || Issue_Ready !== e.rdy || Sb_Err !== e.err) begin
        errors++;
        $display("FAIL vec%0d: got data=%h_%h_%h busy=%b haz=%b rdy=%b err=%b, expected data=%h_%h_%h busy=%b haz=%b rdy=%b err=%b",
                 e.id, REG_R_Data[95:64], REG_R_Data[63:32], REG_R_Data[31:0],
                 REG_R_Busy, Hazard, Issue_Ready, Sb_Err,
                 e.d2, e.d1, e.d0, e.busy, e.haz, e.rdy, e.err);
      end
    end
  end

  task automatic drive(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [2:0] used, input logic ien, input logic [4:0] ia,
                       input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    REG_R_Addr = {a2, a1, a0};
    REG_R_Used = used;
    Issue_En   = ien;
    Issue_Addr = ia;
    REG_W_En   = wen;
    REG_W_Addr = wa;
    REG_W_Data = wd;
  endtask

  task automatic expect_out(input int id, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [2:0] busy,
                            input logic haz, input logic rdy, input logic err);
    exp_t e;
    e.id = id; e.d0 = d0; e.d1 = d1; e.d2 = d2;
    e.busy = busy; e.haz = haz; e.rdy = rdy; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    drive(0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    // reset state
    drive(5, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0);
    expect_out(1, 0, 0, 0, 3'b000, 0, 1, 0); tick();
    RST_N = 1'b1;
    drive(5, 3, 0, 3'b111, 0, 0, 0, 0, 32'h0);
    expect_out(2, 0, 0, 0, 3'b000, 0, 1, 0); tick();

    // x0 ignores writes and issues
    drive(0, 0, 0, 3'b111, 1, 0, 1, 0, 32'hDEADBEEF);
    expect_out(3, 0, 0, 0, 3'b000, 0, 1, 0); tick();
    drive(0, 0, 0, 3'b111, 1, 0, 0, 0, 32'h0);
    expect_out(4, 0, 0, 0, 3'b000, 0, 1, 0); tick();

    // underflow on x9 sets sticky error
    drive(9, 0, 0, 3'b001, 0, 0, 1, 9, 32'hCAFE0009);
    expect_out(5, BYP ? 32'hCAFE0009 : 32'h0, 0, 0, 3'b000, 0, 1, 0); tick();
    drive(9, 9, 0, 3'b011, 0, 0, 0, 0, 32'h0);
    expect_out(6, 32'hCAFE0009, 32'hCAFE0009, 0, 3'b000, 0, 1, 1); tick();

    // RAW on x3
    drive(3, 0, 0, 3'b001, 1, 3, 0, 0, 32'h0);
    expect_out(7, 0, 0, 0, 3'b000, 0, 1, 1); tick();
    drive(3, 0, 0, 3'b001, 0, 0, 0, 0, 32'h0);
    expect_out(8, 0, 0, 0, 3'b001, 1, 1, 1); tick();
    drive(3, 0, 0, 3'b001, 0, 0, 1, 3, 32'h1234);
    expect_out(9, BYP ? 32'h1234 : 32'h0, 0, 0, BYP ? 3'b000 : 3'b001, !BYP, 1, 1); tick();
    drive(3, 0, 0, 3'b001, 0, 0, 0, 0, 32'h0);
    expect_out(10, 32'h1234, 0, 0, 3'b000, 0, 1, 1); tick();

    // counter saturation on x7
    drive(0, 7, 0, 3'b010, 1, 7, 0, 0, 32'h0);
    expect_out(11, 0, 0, 0, 3'b000, 0, 1, 1); tick();
    expect_out(12, 0, 0, 0, 3'b010, 1, 1, 1); tick();
    expect_out(13, 0, 0, 0, 3'b010, 1, 1, 1); tick();
    expect_out(14, 0, 0, 0, 3'b010, 1, 0, 1); tick();
    drive(0, 7, 0, 3'b010, 1, 7, 1, 7, 32'h77);
    expect_out(15, 0, BYP ? 32'h77 : 32'h0, 0, 3'b010, 1, 1, 1); tick();
    drive(0, 7, 0, 3'b010, 0, 7, 0, 0, 32'h0);
    expect_out(16, 0, 32'h77, 0, 3'b010, 1, 0, 1); tick();
    drive(0, 7, 0, 3'b010, 0, 0, 1, 7, 32'h71); tick();
    drive(0, 7, 0, 3'b010, 0, 0, 1, 7, 32'h72); tick();
    drive(0, 7, 0, 3'b010, 0, 0, 1, 7, 32'h73);
    expect_out(17, 0, BYP ? 32'h73 : 32'h72, 0, BYP ? 3'b000 : 3'b010, !BYP, 1, 1); tick();
    drive(0, 7, 0, 3'b010, 0, 0, 0, 0, 32'h0);
    expect_out(18, 0, 32'h73, 0, 3'b000, 0, 1, 1); tick();

    // all three ports on busy x4
    drive(0, 0, 0, 3'b000, 1, 4, 0, 0, 32'h0);
    expect_out(19, 0, 0, 0, 3'b000, 0, 1, 1); tick();
    drive(4, 4, 4, 3'b010, 0, 0, 0, 0, 32'h0);
    expect_out(20, 0, 0, 0, 3'b111, 1, 1, 1); tick();
    drive(4, 4, 4, 3'b000, 0, 0, 0, 0, 32'h0);
    expect_out(21, 0, 0, 0, 3'b111, 0, 1, 1); tick();

    // x5 written, then reset mid-run
    drive(5, 0, 0, 3'b001, 1, 5, 0, 0, 32'h0);
    expect_out(22, 0, 0, 0, 3'b000, 0, 1, 1); tick();
    drive(5, 0, 0, 3'b001, 0, 0, 1, 5, 32'h55);
    expect_out(23, BYP ? 32'h55 : 32'h0, 0, 0, BYP ? 3'b000 : 3'b001, !BYP, 1, 1); tick();
    drive(5, 4, 0, 3'b011, 0, 0, 0, 0, 32'h0);
    expect_out(24, 32'h55, 0, 0, 3'b010, 1, 1, 1); tick();
    drive(5, 4, 9, 3'b111, 0, 4, 0, 0, 32'h0);
    RST_N = 1'b0;
    expect_out(25, 0, 0, 0, 3'b000, 0, 1, 0); tick();
    RST_N = 1'b1;
    expect_out(26, 0, 0, 0, 3'b000, 0, 1, 0); tick();
    drive(4, 0, 0, 3'b001, 1, 4, 0, 0, 32'h0);
    expect_out(27, 0, 0, 0, 3'b000, 0, 1, 0); tick();
    drive(4, 0, 0, 3'b001, 0, 0, 0, 0, 32'h0);
    expect_out(28, 0, 0, 0, 3'b001, 1, 1, 0); tick();

    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
